// File: rtl/serial_link_pkg.sv
// Shared encodings and default sizes for the host-side serial sample link.
package serial_link_pkg;

    localparam int unsigned DEFAULT_LENGTH    = 24;
    localparam int unsigned DEFAULT_CNT_WIDTH = 16;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_e;

    typedef enum logic {
        RX_COLLECT = 1'b0,
        RX_HOLD    = 1'b1
    } rx_state_e;

endpackage

// File: rtl/serial_bit_counter.sv
// Load/step bit counter with a terminal-count flag; holds at the terminal value.
module serial_bit_counter #(
    parameter int unsigned      WIDTH    = 5,
    parameter bit               COUNT_UP = 1'b1,
    parameter logic [WIDTH-1:0] TERMINAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    output logic             terminal_c
);

    logic [WIDTH-1:0] count;

    // Load wins over step; stepping stops at the terminal value so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (step && !terminal_c) begin
            count <= COUNT_UP ? count + WIDTH'(1) : count - WIDTH'(1);
        end
    end

    assign terminal_c = (count == TERMINAL);

endmodule

// File: rtl/serial_link_host.sv
// Host endpoint of the serial sample link: parallel->serial TX, serial->parallel RX.
// Optional word statistics ports enabled by defining SERIAL_LINK_STATS_EN.
module serial_link_host
    import serial_link_pkg::*;
#(
    parameter int unsigned LENGTH = DEFAULT_LENGTH
`ifdef SERIAL_LINK_STATS_EN
    , parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [LENGTH-1:0] iv_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic              o_ser_dout,
    output logic              o_ser_dout_valid,
    input  logic              i_ser_ready,
    input  logic              i_ser_din,
    input  logic              i_ser_din_valid,
    output logic              o_ser_ready,
    output logic [LENGTH-1:0] ov_rx_data,
    output logic              o_rx_valid,
    input  logic              i_rx_ready
`ifdef SERIAL_LINK_STATS_EN
    , output logic [CNT_WIDTH-1:0] ov_tx_words,
    output logic [CNT_WIDTH-1:0] ov_rx_words
`endif
);

    localparam int unsigned   CW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

    tx_state_e         tx_state, tx_state_nxt;
    logic [LENGTH-1:0] tx_shreg;
    logic              tx_load, tx_bit_xfer, tx_last_c;

    rx_state_e         rx_state, rx_state_nxt;
    logic [LENGTH-2:0] rx_shreg;
    logic [LENGTH-1:0] rx_word_c;
    logic              rx_bit_xfer, rx_done, rx_release, rx_last_c;

    // TX state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) tx_state <= TX_IDLE;
        else          tx_state <= tx_state_nxt;
    end

    // TX next state and handshake outputs, all gated by i_en.
    always_comb begin
        tx_state_nxt     = tx_state;
        o_tx_ready       = 1'b0;
        o_ser_dout_valid = 1'b0;
        tx_load          = 1'b0;
        tx_bit_xfer      = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                o_tx_ready = i_en;
                if (i_en && i_tx_valid) begin
                    tx_load      = 1'b1;
                    tx_state_nxt = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                o_ser_dout_valid = i_en;
                if (i_en && i_ser_ready) begin
                    tx_bit_xfer = 1'b1;
                    if (tx_last_c) tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // TX shift register, MSB leaves first; empties to zero after a full word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)         tx_shreg <= '0;
        else if (tx_load)     tx_shreg <= iv_tx_data;
        else if (tx_bit_xfer) tx_shreg <= {tx_shreg[LENGTH-2:0], 1'b0};
    end

    assign o_ser_dout = tx_shreg[LENGTH-1];

    serial_bit_counter #(
        .WIDTH    (CW),
        .COUNT_UP (1'b0),
        .TERMINAL ('0)
    ) u_tx_cnt (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .load       (tx_load),
        .load_val   (LAST),
        .step       (tx_bit_xfer),
        .terminal_c (tx_last_c)
    );

    // RX state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rx_state <= RX_COLLECT;
        else          rx_state <= rx_state_nxt;
    end

    // RX next state and handshake outputs, all gated by i_en.
    always_comb begin
        rx_state_nxt = rx_state;
        o_ser_ready  = 1'b0;
        o_rx_valid   = 1'b0;
        rx_bit_xfer  = 1'b0;
        rx_done      = 1'b0;
        rx_release   = 1'b0;
        case (rx_state)
            RX_COLLECT: begin
                o_ser_ready = i_en;
                if (i_en && i_ser_din_valid) begin
                    rx_bit_xfer = 1'b1;
                    if (rx_last_c) begin
                        rx_done      = 1'b1;
                        rx_state_nxt = RX_HOLD;
                    end
                end
            end
            RX_HOLD: begin
                o_rx_valid = i_en;
                if (i_en && i_rx_ready) begin
                    rx_release   = 1'b1;
                    rx_state_nxt = RX_COLLECT;
                end
            end
            default: rx_state_nxt = RX_COLLECT;
        endcase
    end

    // Word as it stands once the current incoming bit is appended.
    assign rx_word_c = {rx_shreg, i_ser_din};

    // RX shift register and the held output word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_shreg   <= '0;
            ov_rx_data <= '0;
        end else begin
            if (rx_bit_xfer) rx_shreg   <= rx_word_c[LENGTH-2:0];
            if (rx_done)     ov_rx_data <= rx_word_c;
        end
    end

    serial_bit_counter #(
        .WIDTH    (CW),
        .COUNT_UP (1'b1),
        .TERMINAL (LAST)
    ) u_rx_cnt (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .load       (rx_release),
        .load_val   ('0),
        .step       (rx_bit_xfer),
        .terminal_c (rx_last_c)
    );

`ifdef SERIAL_LINK_STATS_EN
    // Completed-word counters; transfers are already gated by i_en so they freeze with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_tx_words <= '0;
            ov_rx_words <= '0;
        end else begin
            if (tx_bit_xfer && tx_last_c) ov_tx_words <= ov_tx_words + CNT_WIDTH'(1);
            if (rx_release)               ov_rx_words <= ov_rx_words + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_serial_link_host.sv
// Bench for serial_link_host: directed steps plus a random phase, checked every
// cycle against a queue-based model of the link.
module tb_serial_link_host;

    localparam int unsigned LEN = 24;

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic           i_en;
    logic [LEN-1:0] iv_tx_data;
    logic           i_tx_valid;
    logic           o_tx_ready;
    logic           o_ser_dout;
    logic           o_ser_dout_valid;
    logic           i_ser_ready;
    logic           i_ser_din;
    logic           i_ser_din_valid;
    logic           o_ser_ready;
    logic [LEN-1:0] ov_rx_data;
    logic           o_rx_valid;
    logic           i_rx_ready;
`ifdef SERIAL_LINK_STATS_EN
    logic [15:0]    ov_tx_words;
    logic [15:0]    ov_rx_words;
`endif

    serial_link_host dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_en             (i_en),
        .iv_tx_data       (iv_tx_data),
        .i_tx_valid       (i_tx_valid),
        .o_tx_ready       (o_tx_ready),
        .o_ser_dout       (o_ser_dout),
        .o_ser_dout_valid (o_ser_dout_valid),
        .i_ser_ready      (i_ser_ready),
        .i_ser_din        (i_ser_din),
        .i_ser_din_valid  (i_ser_din_valid),
        .o_ser_ready      (o_ser_ready),
        .ov_rx_data       (ov_rx_data),
        .o_rx_valid       (o_rx_valid),
        .i_rx_ready       (i_rx_ready)
`ifdef SERIAL_LINK_STATS_EN
        , .ov_tx_words    (ov_tx_words),
        .ov_rx_words      (ov_rx_words)
`endif
    );

    always #5 i_clk = ~i_clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model state: bits still owed on the TX wire, bits gathered on RX, held word.
    bit             m_tx_bits[$];
    bit             m_rx_bits[$];
    bit             m_hold;
    logic [LEN-1:0] m_rx_word;
    int unsigned    m_txw, m_rxw;

    // Stimulus sources and modes.
    logic [LEN-1:0] tx_src[$];
    bit             rx_src[$];
    bit             loopback = 1'b0;
    bit             rnd = 1'b0;
    int             ready_mode = 0;
    logic [LEN-1:0] got[$];

    // Samples taken at the check point of the latest cycle.
    logic           s_txr, s_dout, s_dval, s_serr, s_rxv;
    logic [LEN-1:0] s_rxd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tx_bits.delete();
        m_rx_bits.delete();
        m_hold    = 1'b0;
        m_rx_word = '0;
        m_txw     = 0;
        m_rxw     = 0;
    endtask

    task automatic check_all();
        logic exp_dout;
        exp_dout = 1'b0;
        if (m_tx_bits.size() != 0) exp_dout = m_tx_bits[0];
        chk("tx_ready",   32'(o_tx_ready),       32'(i_en && (m_tx_bits.size() == 0)));
        chk("dout_valid", 32'(o_ser_dout_valid), 32'(i_en && (m_tx_bits.size() != 0)));
        chk("dout",       32'(o_ser_dout),       32'(exp_dout));
        chk("ser_ready",  32'(o_ser_ready),      32'(i_en && !m_hold));
        chk("rx_valid",   32'(o_rx_valid),       32'(i_en && m_hold));
        chk("rx_data",    32'(ov_rx_data),       32'(m_rx_word));
`ifdef SERIAL_LINK_STATS_EN
        chk("tx_words",   32'(ov_tx_words),      32'(16'(m_txw)));
        chk("rx_words",   32'(ov_rx_words),      32'(16'(m_rxw)));
`endif
    endtask

    // Advance the model by one clock using the inputs that were presented.
    task automatic model_step();
        logic [LEN-1:0] w;
        if (!i_en) return;
        if (m_tx_bits.size() == 0) begin
            if (i_tx_valid) begin
                for (int b = 0; b < int'(LEN); b++) m_tx_bits.push_back(iv_tx_data[LEN-1-b]);
                if (!rnd && tx_src.size() != 0) void'(tx_src.pop_front());
            end
        end else if (i_ser_ready) begin
            void'(m_tx_bits.pop_front());
            if (m_tx_bits.size() == 0) m_txw++;
        end
        if (!m_hold) begin
            if (i_ser_din_valid) begin
                m_rx_bits.push_back(i_ser_din);
                if (!rnd && !loopback && rx_src.size() != 0) void'(rx_src.pop_front());
                if (m_rx_bits.size() == LEN) begin
                    w = '0;
                    for (int i = 0; i < int'(LEN); i++) if (m_rx_bits[i]) w[LEN-1-i] = 1'b1;
                    m_rx_word = w;
                    m_rx_bits.delete();
                    m_hold = 1'b1;
                end
            end
        end else if (i_rx_ready) begin
            m_hold = 1'b0;
            m_rxw++;
        end
    endtask

    task automatic drive();
        if (rnd) begin
            i_en            = ($urandom_range(0, 7) != 0);
            i_tx_valid      = 1'($urandom_range(0, 1));
            iv_tx_data      = LEN'($urandom);
            i_ser_ready     = 1'($urandom_range(0, 1));
            i_ser_din       = 1'($urandom_range(0, 1));
            i_ser_din_valid = 1'($urandom_range(0, 1));
            i_rx_ready      = 1'($urandom_range(0, 1));
        end else begin
            i_tx_valid = (tx_src.size() != 0);
            iv_tx_data = '0;
            if (tx_src.size() != 0) iv_tx_data = tx_src[0];
            if (!loopback) begin
                i_ser_din_valid = (rx_src.size() != 0);
                i_ser_din       = 1'b0;
                if (rx_src.size() != 0) i_ser_din = rx_src[0];
                if (ready_mode == 1) i_ser_ready = ~i_ser_ready;
                else                 i_ser_ready = 1'b1;
            end
        end
    endtask

    // One clock: drive, settle, check against the model, clock, update model.
    task automatic cyc();
        drive();
        #1;
        if (loopback) begin
            i_ser_din       = o_ser_dout;
            i_ser_din_valid = o_ser_dout_valid;
            i_ser_ready     = o_ser_ready;
            #1;
        end
        check_all();
        s_txr  = o_tx_ready;
        s_dout = o_ser_dout;
        s_dval = o_ser_dout_valid;
        s_serr = o_ser_ready;
        s_rxv  = o_rx_valid;
        s_rxd  = ov_rx_data;
        if (o_rx_valid && i_rx_ready) got.push_back(ov_rx_data);
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        model_reset();
        tx_src.delete();
        rx_src.delete();
        check_all();
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        logic [LEN-1:0] cap;
        logic [LEN-1:0] w;
        int             busy;

        i_rst_n = 1'b0; i_en = 1'b1; iv_tx_data = '0; i_tx_valid = 1'b0;
        i_ser_ready = 1'b1; i_ser_din = 1'b0; i_ser_din_valid = 1'b0; i_rx_ready = 1'b1;
        model_reset();
        do_reset();

        // TX 0xA5000F with a always-ready peer: 24 busy cycles.
        tx_src.push_back(24'hA5000F);
        cyc();
        busy = 0; cap = '0;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (s_txr) break;
            busy++;
            if (s_dval && i_ser_ready) cap = {cap[LEN-2:0], s_dout};
        end
        chk("tx1_busy", 32'(busy), 32'd24);
        chk("tx1_bits", 32'(cap), 32'h00A5000F);

        // TX 0x800001 with the peer toggling ready: 48 busy cycles, no lost bits.
        ready_mode = 1; i_ser_ready = 1'b0;
        tx_src.push_back(24'h800001);
        cyc();
        busy = 0; cap = '0;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (s_txr) break;
            busy++;
            if (s_dval && i_ser_ready) cap = {cap[LEN-2:0], s_dout};
        end
        chk("tx2_busy", 32'(busy), 32'd48);
        chk("tx2_bits", 32'(cap), 32'h00800001);
        ready_mode = 0;

        // RX 0x3C3C3C with the consumer stalled, then released.
        i_rx_ready = 1'b0;
        w = 24'h3C3C3C;
        for (int b = LEN - 1; b >= 0; b--) rx_src.push_back(w[b]);
        for (int k = 0; k < int'(LEN); k++) cyc();
        cyc();
        chk("rx_valid_lat", 32'(s_rxv), 32'd1);
        chk("rx_word",      32'(s_rxd), 32'h003C3C3C);
        chk("rx_hold_rdy",  32'(s_serr), 32'd0);
        for (int k = 0; k < 3; k++) cyc();
        i_rx_ready = 1'b1;
        cyc();
        chk("rx_rel_valid", 32'(s_rxv), 32'd1);
        cyc();
        chk("rx_rel_rdy",   32'(s_serr), 32'd1);
        chk("rx_rel_clr",   32'(s_rxv), 32'd0);

        // Loopback of two words.
        got.delete();
        loopback = 1'b1;
        tx_src.push_back(24'h123456);
        tx_src.push_back(24'hFEDCBA);
        for (int k = 0; k < 200 && got.size() < 2; k++) cyc();
        chk("lb_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("lb_word0", 32'(got[0]), 32'h00123456);
            chk("lb_word1", 32'(got[1]), 32'h00FEDCBA);
        end
        loopback = 1'b0;

        // Random traffic on both halves, including random i_en.
        rnd = 1'b1;
        for (int k = 0; k < 600; k++) cyc();
        rnd = 1'b0;
        i_en = 1'b1; i_tx_valid = 1'b0; i_ser_din_valid = 1'b0; i_rx_ready = 1'b1;
        do_reset();

        // Partial words in both directions, then reset.
        tx_src.push_back(24'hFFFFFF);
        cyc();
        w = 24'hFFFFFF;
        for (int b = LEN - 1; b >= 0; b--) rx_src.push_back(w[b]);
        for (int k = 0; k < 10; k++) cyc();
        do_reset();
        chk("rst_dout",  32'(o_ser_dout), 32'd0);
        chk("rst_rxd",   32'(ov_rx_data), 32'd0);

        // Fresh word after reset, then a word interrupted by i_en low.
        got.delete();
        loopback = 1'b1;
        tx_src.push_back(24'h000001);
        for (int k = 0; k < 100 && got.size() < 1; k++) cyc();
        chk("post_rst_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("post_rst_word", 32'(got[0]), 32'h00000001);

        got.delete();
        tx_src.push_back(24'h5A5A5A);
        for (int k = 0; k < 8; k++) cyc();
        i_en = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        i_en = 1'b1;
        for (int k = 0; k < 100 && got.size() < 1; k++) cyc();
        chk("en_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("en_word", 32'(got[0]), 32'h005A5A5A);

        got.delete();
        tx_src.push_back(24'hC0FFEE);
        for (int k = 0; k < 100 && got.size() < 1; k++) cyc();
        chk("w3_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("w3_word", 32'(got[0]), 32'h00C0FFEE);
        cyc();
`ifdef SERIAL_LINK_STATS_EN
        chk("stats_tx3", 32'(ov_tx_words), 32'd3);
        chk("stats_rx3", 32'(ov_rx_words), 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
